sdu_dump: RTL and testbench



---
 rtl/sdu_dump.sv | 172 +++++++++++++++++
 tb/tb_sdu_dump.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sdu_dump.sv
// SDU readout engine: sweeps RF or DM words through the CPU debug ports and
// streams them as bytes. Define SDU_DUMP_HEX_EN for lowercase-hex + newline output.
module sdu_dump (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        abort,
  output logic [4:0]  sdu_rf_addr,
  input  logic [31:0] sdu_rf_rdata,
  output logic [31:0] sdu_dm_addr,
  input  logic [31:0] sdu_dm_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CAPT, S_SEND, S_DONE
  } state_t;

`ifdef SDU_DUMP_HEX_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd3;
`endif

  state_t      state_q, state_d;
  logic        op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  rem_q, rem_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  rf_addr_q, rf_addr_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] nxt_addr;
  logic [31:0] cap_word;
  logic [31:0] acc_addr;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [3:0] i);
    logic [31:0] s;
`ifdef SDU_DUMP_HEX_EN
    logic [7:0] nib;
    if (i == 4'd8) return 8'h0a;
    s   = w >> {3'd7 - i[2:0], 2'b00};
    nib = {4'h0, s[3:0]};
    return (nib < 8'd10) ? 8'h30 + nib : 8'h57 + nib;
`else
    s = w >> {i, 3'b000};
    return s[7:0];
`endif
  endfunction

  // RF index wraps inside 5 bits; DM address wraps naturally at 2^32.
  assign nxt_addr = op_q ? addr_q + 32'd4 : {27'd0, addr_q[4:0] + 5'd1};
  assign cap_word = op_q ? sdu_dm_rdata : sdu_rf_rdata;
  assign acc_addr = cmd_op ? {cmd_addr[31:2], 2'b00} : {27'd0, cmd_addr[4:0]};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    word_d    = word_q;
    idx_d     = idx_q;
    rf_addr_d = rf_addr_q;
    dm_addr_d = dm_addr_q;
    tx_data_d = tx_data_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        op_d   = cmd_op;
        addr_d = acc_addr;
        rem_d  = cmd_len;
        if (cmd_len == 8'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ADDR;
          if (cmd_op) dm_addr_d = acc_addr;
          else        rf_addr_d = acc_addr[4:0];
        end
      end
      S_ADDR: state_d = S_CAPT;
      S_CAPT: begin
        word_d    = cap_word;
        idx_d     = 4'd0;
        tx_data_d = byte_sel(cap_word, 4'd0);
        state_d   = S_SEND;
      end
      S_SEND: if (tx_ready) begin
        if (idx_q == LAST_IDX) begin
          rem_d = rem_q - 8'd1;
          idx_d = 4'd0;
          if (rem_q == 8'd1) begin
            state_d = S_DONE;
          end else begin
            addr_d  = nxt_addr;
            state_d = S_ADDR;
            if (op_q) dm_addr_d = nxt_addr;
            else      rf_addr_d = nxt_addr[4:0];
          end
        end else begin
          idx_d     = idx_q + 4'd1;
          tx_data_d = byte_sel(word_q, idx_q + 4'd1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any in-flight progress; debug ports keep their last address.
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      rf_addr_d = rf_addr_q;
      dm_addr_d = dm_addr_q;
    end
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    tx_valid_d  = (state_d == S_SEND);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      addr_q      <= 32'd0;
      rem_q       <= 8'd0;
      word_q      <= 32'd0;
      idx_q       <= 4'd0;
      rf_addr_q   <= 5'd0;
      dm_addr_q   <= 32'd0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      rf_addr_q   <= rf_addr_d;
      dm_addr_q   <= dm_addr_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign sdu_rf_addr = rf_addr_q;
  assign sdu_dm_addr = dm_addr_q;

endmodule

// File: tb/tb_sdu_dump.sv
// Randomized bench for sdu_dump: stub CPU ports, expected byte stream and
// completion time derived from the word list and the output format rules.
module tb_sdu_dump;

`ifdef SDU_DUMP_HEX_EN
  localparam int N = 9;
`else
  localparam int N = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_op, abort;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [4:0]  sdu_rf_addr;
  logic [31:0] sdu_rf_rdata, sdu_dm_addr, sdu_dm_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, busy, done;

  logic [31:0] rf_salt = 32'd0;
  logic [31:0] dm_salt = 32'd0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign sdu_rf_rdata = 32'h1000 + {27'd0, sdu_rf_addr} + rf_salt;
  assign sdu_dm_rdata = sdu_dm_addr ^ dm_salt;

  sdu_dump dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .abort(abort),
    .sdu_rf_addr(sdu_rf_addr), .sdu_rf_rdata(sdu_rf_rdata),
    .sdu_dm_addr(sdu_dm_addr), .sdu_dm_rdata(sdu_dm_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // Expected stream: list of words at the swept addresses, then formatted.
  task automatic build_exp(input logic op, input logic [31:0] addr, input int len);
    logic [31:0] w, a;
    string s;
    exp_q = {};
    for (int i = 0; i < len; i++) begin
      if (op) begin
        a = {addr[31:2], 2'b00} + 32'(4 * i);
        w = a ^ dm_salt;
      end else begin
        w = 32'h1000 + 32'((int'(addr[4:0]) + i) % 32) + rf_salt;
      end
`ifdef SDU_DUMP_HEX_EN
      s = $sformatf("%08h\n", w);
      for (int k = 0; k < 9; k++) exp_q.push_back(s[k]);
`else
      for (int k = 0; k < 4; k++) exp_q.push_back(8'((w >> (8 * k)) & 32'hff));
`endif
    end
  endtask

  // rmode: 0 = always ready, 1 = ready pattern 1,0,0,..., 2 = random.
  task automatic run_dump(input logic op, input logic [31:0] addr, input int len,
                          input int rmode, input int abort_at);
    int c, stalls, done_c, exp_done;
    bit aborted, prev_stall;
    logic [7:0]  prev_data;
    logic [4:0]  rf0;
    logic [31:0] dm0;
    build_exp(op, addr, len);
    got_q = {};
    rf0 = sdu_rf_addr;
    dm0 = sdu_dm_addr;
    @(negedge clk);
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = 8'(len);
    c = 0; stalls = 0; done_c = -1; aborted = 0; prev_stall = 0; prev_data = 8'h00;
    while (c < 3000) begin
      @(negedge clk);
      c++;
      if (aborted) break;
      case (rmode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ((c % 3) == 1);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall) begin
        chk("tx_valid_hold", {31'd0, tx_valid}, 32'd1);
        chk("tx_data_hold", {24'd0, tx_data}, {24'd0, prev_data});
      end
      chk("busy_during", {31'd0, busy}, 32'd1);
      if (done) begin
        done_c = c;
        break;
      end
      prev_stall = 1'b0;
      if (tx_valid) begin
        if (abort_at >= 0 && got_q.size() == abort_at) begin
          abort = 1'b1; tx_ready = 1'b0; aborted = 1;
        end else if (tx_ready) begin
          got_q.push_back(tx_data);
        end else begin
          stalls++;
          prev_stall = 1'b1;
          prev_data  = tx_data;
        end
      end
      // Commands presented while busy must be ignored.
      cmd_valid = aborted ? 1'b0 : 1'($urandom_range(0, 1));
      cmd_op    = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      cmd_len   = 8'($urandom_range(1, 9));
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    if (aborted) begin
      chk("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_nbytes", got_q.size(), abort_at);
      for (int i = 0; i < got_q.size(); i++)
        chk($sformatf("abort_byte%0d", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end else begin
      exp_done = (len == 0) ? 1 : 1 + len * (N + 2) + stalls;
      chk("done_cycle", done_c, exp_done);
      chk("nbytes", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        chk($sformatf("byte%0d", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
    end
    if (len == 0 || aborted && abort_at == 0 && exp_q.size() == 0) begin
      chk("len0_rf_addr", {27'd0, sdu_rf_addr}, {27'd0, rf0});
      chk("len0_dm_addr", sdu_dm_addr, dm0);
    end else if (op) begin
      chk("rf_addr_held", {27'd0, sdu_rf_addr}, {27'd0, rf0});
    end else begin
      chk("dm_addr_held", sdu_dm_addr, dm0);
    end
  endtask

  initial begin
    int len, n, ab;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0;
    abort = 1'b0; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_rf_addr", {27'd0, sdu_rf_addr}, 32'd0);
    chk("rst_dm_addr", sdu_dm_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    run_dump(1'b0, 32'd30, 3, 0, -1);            // RF wrap 30,31,0
    run_dump(1'b1, 32'hFFFF_FFFE, 2, 0, -1);     // DM wrap, low bits ignored
    run_dump(1'b0, 32'd5, 1, 1, -1);             // backpressure
    run_dump(1'b1, 32'h0000_0100, 0, 0, -1);     // len=0
    run_dump(1'b1, 32'h0000_0040, 4, 0, N + 1);  // abort mid word 2 of 4
    run_dump(1'b0, 32'd7, 2, 0, -1);             // accepted right after abort

    for (int t = 0; t < 24; t++) begin
      rf_salt = $urandom;
      dm_salt = $urandom;
      len = $urandom_range(0, 5);
      n   = len * N;
      ab  = (n > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_dump(1'($urandom_range(0, 1)), $urandom, len, 2, ab);
    end

    // Asynchronous reset in the middle of a dump.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 32'h0000_0800; cmd_len = 8'd3; tx_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("arst_dm_addr", sdu_dm_addr, 32'd0);
    chk("arst_tx_data", {24'd0, tx_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_dump(1'b0, 32'd31, 2, 2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
